alsu_cmd_issuer: RTL and testbench

- Upstream feeder and result collector for the ALSU datapath stage.
- Accepts packed ALSU commands on a valid/ready interface and buffers them in a command FIFO.
- Drives the ALSU input pins from registers, one command per cycle, and tracks the fixed 2-edge ALSU latency.
- Captures each ALSU `out` value into a result FIFO, tagged and flagged invalid, with valid/ready backpressure.

---
 rtl/alsu_pkg.sv | 62 ++++++
 rtl/alsu_sync_fifo.sv | 46 ++++
 rtl/alsu_cmd_issuer.sv | 145 ++++++++++++++
 tb/tb_alsu_cmd_issuer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared types and helpers for the ALSU command issuer: command field layout,
// result record, NOP encoding and the invalid-combination predictor.
package alsu_pkg;

    localparam int CMD_W     = 16;
    localparam int OUT_W     = 6;
    localparam int TAG_W     = 2;

    localparam int A_LSB     = 13;
    localparam int B_LSB     = 10;
    localparam int OP_LSB    = 7;
    localparam int CIN_BIT   = 6;
    localparam int SER_BIT   = 5;
    localparam int RED_A_BIT = 4;
    localparam int RED_B_BIT = 3;
    localparam int BYP_A_BIT = 2;
    localparam int BYP_B_BIT = 1;
    localparam int DIR_BIT   = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
        logic       direction;
    } cmd_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             invalid;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam cmd_t NOP_CMD = '0;

    function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] d);
        cmd_t c;
        c.a         = d[A_LSB +: 3];
        c.b         = d[B_LSB +: 3];
        c.opcode    = d[OP_LSB +: 3];
        c.cin       = d[CIN_BIT];
        c.serial_in = d[SER_BIT];
        c.red_op_a  = d[RED_A_BIT];
        c.red_op_b  = d[RED_B_BIT];
        c.bypass_a  = d[BYP_A_BIT];
        c.bypass_b  = d[BYP_B_BIT];
        c.direction = d[DIR_BIT];
        return c;
    endfunction

    // Reductions only make sense for AND/XOR; opcodes 6 and 7 are unused.
    function automatic logic is_invalid(input cmd_t c);
        return ((c.red_op_a | c.red_op_b) & (c.opcode[1] | c.opcode[2]))
             | (c.opcode[1] & c.opcode[2]);
    endfunction

endpackage

// File: rtl/alsu_sync_fifo.sv
// Synchronous FIFO with register storage; the head entry is presented directly
// from storage, so dout has no combinational path from pop.
module alsu_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Feeds buffered commands to the ALSU one per cycle, tracks its fixed latency
// and collects tagged results under a credit limit equal to the result depth.
module alsu_cmd_issuer
    import alsu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ALSU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_data,
    output logic [2:0]       alsu_A,
    output logic [2:0]       alsu_B,
    output logic [2:0]       alsu_opcode,
    output logic             alsu_cin,
    output logic             alsu_serial_in,
    output logic             alsu_red_op_A,
    output logic             alsu_red_op_B,
    output logic             alsu_bypass_A,
    output logic             alsu_bypass_B,
    output logic             alsu_direction,
    input  logic [OUT_W-1:0] alsu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_invalid,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int STAGES = ALSU_LAT;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                         cmd_full;
    logic                         cmd_empty;
    logic [CMD_W-1:0]             cmd_head;
    logic                         res_full;
    logic                         res_empty;
    logic                         cmd_push;
    logic                         issue;
    logic                         res_push;
    logic                         res_pop;
    logic [CW-1:0]                credits;
    logic [TAG_W-1:0]             tag_cnt;
    cmd_t                         head;
    cmd_t                         drv;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              inv_pipe;
    logic [STAGES:0][TAG_W-1:0]   tag_pipe;
    res_t                         res_in;
    res_t                         res_out;

    assign cmd_ready = !cmd_full && !rst;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign head      = unpack_cmd(cmd_head);
    // Credits cover both in-flight and stored results, so the result FIFO can't overflow.
    assign issue     = !cmd_empty && (credits < CW'(DEPTH));
    assign res_push  = vld_pipe[STAGES];
    assign res_pop   = !res_empty && res_ready;

    alsu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .din   (cmd_data),
        .pop   (issue),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    // Idle cycles drive a NOP so the ALSU settles to 0 rather than holding state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv     <= NOP_CMD;
            tag_cnt <= '0;
        end else if (issue) begin
            drv     <= head;
            tag_cnt <= tag_cnt + 1'b1;
        end else begin
            drv     <= NOP_CMD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            inv_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            inv_pipe <= {inv_pipe[STAGES-1:0], is_invalid(head)};
            tag_pipe <= {tag_pipe[STAGES-1:0], tag_cnt};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credits <= '0;
        else begin
            unique case ({issue, res_pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign res_in.data    = alsu_out;
    assign res_in.invalid = inv_pipe[STAGES];
    assign res_in.tag     = tag_pipe[STAGES];

    alsu_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (res_in),
        .pop   (res_pop),
        .dout  (res_out),
        .full  (res_full),
        .empty (res_empty)
    );

    a_no_res_overflow: assert property (@(posedge clk) disable iff (rst) !(res_push && res_full));

    assign alsu_A         = drv.a;
    assign alsu_B         = drv.b;
    assign alsu_opcode    = drv.opcode;
    assign alsu_cin       = drv.cin;
    assign alsu_serial_in = drv.serial_in;
    assign alsu_red_op_A  = drv.red_op_a;
    assign alsu_red_op_B  = drv.red_op_b;
    assign alsu_bypass_A  = drv.bypass_a;
    assign alsu_bypass_B  = drv.bypass_b;
    assign alsu_direction = drv.direction;

    assign res_valid   = !res_empty;
    assign res_data    = res_out.data;
    assign res_invalid = res_out.invalid;
    assign res_tag     = res_out.tag;
    assign busy        = !cmd_empty || (credits != '0);

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Bench for alsu_cmd_issuer: a behavioural ALSU closes the loop, a scoreboard
// queue holds expected {data, invalid, tag} filled on command accept.
module tb_alsu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0]  alsu_out;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_data;
    logic        res_invalid;
    logic [1:0]  res_tag;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  tag_cnt = '0;
    logic [8:0]  exp_q[$];

    always #5 clk = ~clk;

    alsu_cmd_issuer #(.DEPTH(4), .ALSU_LAT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .alsu_A         (alsu_A),
        .alsu_B         (alsu_B),
        .alsu_opcode    (alsu_opcode),
        .alsu_cin       (alsu_cin),
        .alsu_serial_in (alsu_serial_in),
        .alsu_red_op_A  (alsu_red_op_A),
        .alsu_red_op_B  (alsu_red_op_B),
        .alsu_bypass_A  (alsu_bypass_A),
        .alsu_bypass_B  (alsu_bypass_B),
        .alsu_direction (alsu_direction),
        .alsu_out       (alsu_out),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_invalid    (res_invalid),
        .res_tag        (res_tag),
        .busy           (busy)
    );

    // Behavioural ALSU: inputs registered on one edge, out registered on the next.
    logic [2:0] a_r, b_r, op_r;
    logic       cin_r, ser_r, ra_r, rb_r, ba_r, bb_r, dir_r;

    always @(posedge clk or posedge rst) begin
        if (rst)
            {a_r, b_r, op_r, cin_r, ser_r, ra_r, rb_r, ba_r, bb_r, dir_r} <= '0;
        else begin
            a_r <= alsu_A;   b_r <= alsu_B;   op_r <= alsu_opcode;
            cin_r <= alsu_cin;   ser_r <= alsu_serial_in;
            ra_r <= alsu_red_op_A;   rb_r <= alsu_red_op_B;
            ba_r <= alsu_bypass_A;   bb_r <= alsu_bypass_B;   dir_r <= alsu_direction;
        end
    end

    function automatic logic [5:0] alsu_f(input logic [5:0] prev);
        logic signed [5:0] ax, bx;
        ax = {{3{a_r[2]}}, a_r};
        bx = {{3{b_r[2]}}, b_r};
        if (((ra_r | rb_r) & (op_r[1] | op_r[2])) | (op_r[1] & op_r[2])) return '0;
        if (ba_r) return ax;
        if (bb_r) return bx;
        case (op_r)
            3'd0:    return ra_r ? {5'b0, &a_r} : rb_r ? {5'b0, &b_r} : (ax & bx);
            3'd1:    return ra_r ? {5'b0, ^a_r} : rb_r ? {5'b0, ^b_r} : (ax ^ bx);
            3'd2:    return ax + bx + {5'b0, cin_r};
            3'd3:    return ax * bx;
            3'd4:    return dir_r ? {prev[4:0], ser_r} : {ser_r, prev[5:1]};
            3'd5:    return dir_r ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) alsu_out <= '0;
        else     alsu_out <= alsu_f(alsu_out);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic cin,
                                       input logic ser, input logic ra, input logic rb,
                                       input logic ba, input logic bb, input logic dir);
        return {a, b, op, cin, ser, ra, rb, ba, bb, dir};
    endfunction

    // Returns #1 after the accepting edge, so consecutive calls accept back-to-back.
    task automatic send(input logic [15:0] c, input logic [5:0] ed, input logic ei,
                        input bit exp_on);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = c;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            if (exp_on) exp_q.push_back({ed, ei, tag_cnt});
            tag_cnt = tag_cnt + 2'd1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1 chk("drain_left", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("idle_busy", busy, 1'b0);
    endtask

    // Scoreboard pop: a result is consumed on the next edge when valid && ready.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {res_data, res_invalid, res_tag}, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("res_data", res_data, e[8:3]);
                chk("res_invalid", res_invalid, e[2]);
                chk("res_tag", res_tag, e[1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0;
        #1;
        chk("rst_pins", {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_red_op_A,
                         alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction}, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_res", {res_valid, res_data, res_invalid, res_tag, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Add with carry, plus accept-to-valid latency (accept edge counts as edge 1).
        res_ready = 1'b1;
        send(mk(3'd3, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd6, 1'b0, 1'b1);
        edges = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk);
            edges++;
        end
        chk("latency", edges, 32'd5);
        drain();

        // Signed multiply
        send(mk(3'b111, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'b111101, 1'b0, 1'b1);
        drain();

        // Invalid opcode, then XOR reduction of A
        send(mk(3'd5, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd0, 1'b1, 1'b1);
        send(mk(3'b011, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 6'd0, 1'b0, 1'b1);
        drain();

        // Back-to-back: add gives 1, then shift left pulling in serial_in gives 3
        send(mk(3'd1, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd1, 1'b0, 1'b1);
        send(mk(3'd0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 6'd3, 1'b0, 1'b1);
        drain();

        // Idle reset pulse so the backpressure run starts at tag 0
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tag_cnt = '0;
        @(posedge clk); #1;

        // Backpressure: credits cap at 4, command FIFO fills, 9th stalls
        res_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            send(mk(3'(k % 4), 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 6'(k % 4 + 1), 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        cmd_valid = 1'b1;
        cmd_data  = mk(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
        end
        chk("stall_busy", busy, 1'b1);
        chk("stall_head", {res_valid, res_tag, res_data}, {1'b1, 2'd0, 6'd1});
        @(posedge clk); #1;
        res_ready = 1'b1;
        send(mk(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd1, 1'b0, 1'b1);
        drain();

        // Reset with 2 in flight and 1 queued: nothing may be reported
        send(mk(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd2, 1'b0, 1'b0);
        send(mk(3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd3, 1'b0, 1'b0);
        send(mk(3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd4, 1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pins", {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_red_op_A,
                             alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction}, 32'd0);
        chk("mid_rst_res", {res_valid, res_data, res_invalid, res_tag, busy}, 32'd0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tag_cnt = '0;
        @(posedge clk); #1;
        send(mk(3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'd4, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
